mac_seq_ctrl: RTL and testbench

Sequencer that drives one `mac_unit` through a length-N dot product (one conv-kernel tap per MAC op) and returns a rounded, saturated Q1.15 result. It fetches operand pairs from the input and weight buffers and feeds each running sum back through `acc_in`. It respects the `mac_unit` pipeline skew and waits for `valid_out` before issuing the next tap. It sits between the layer scheduler (start/result handshake) and a single `mac_unit` instance.

---
 rtl/mac_ctrl_pkg.sv | 36 +++
 rtl/mac_seq_ctrl_if.sv | 29 ++
 rtl/fxp_round_sat.sv | 35 +++
 rtl/mac_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC sequencer and the requantisation helpers.
//   state_e       : sequencer FSM states
//   rnd_const()   : round-half-up constant for a given number of fractional bits
//   sat_max/min() : signed saturation limits for a given result width
//   Rnd/SatMax/SatMin : the above for the default Q1.15 format
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssueA,
    StIssue,
    StWait,
    StDone
  } state_e;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefFracBits  = 15;

  function automatic longint rnd_const(input int unsigned frac_bits);
    return 64'sd1 <<< (frac_bits - 1);
  endfunction

  function automatic longint sat_max(input int unsigned data_width);
    return (64'sd1 <<< (data_width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int unsigned data_width);
    return -(64'sd1 <<< (data_width - 1));
  endfunction

  localparam longint Rnd    = rnd_const(DefFracBits);
  localparam longint SatMax = sat_max(DefDataWidth);
  localparam longint SatMin = sat_min(DefDataWidth);

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Issue/result channel between the sequencer and a single mac_unit.
//   mac_en, mac_valid_in : issue strobes (sequencer -> MAC)
//   mac_a, mac_b         : signed operands
//   mac_acc_in           : running sum fed into the MAC
//   mac_acc_out          : MAC result (MAC -> sequencer)
//   mac_valid_out        : result valid
// master = sequencer side, slave = MAC side.
interface mac_seq_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
);
  logic                         mac_en;
  logic                         mac_valid_in;
  logic signed [DATA_WIDTH-1:0] mac_a;
  logic signed [DATA_WIDTH-1:0] mac_b;
  logic signed [ACC_WIDTH-1:0]  mac_acc_in;
  logic signed [ACC_WIDTH-1:0]  mac_acc_out;
  logic                         mac_valid_out;

  modport master (
    output mac_en, mac_valid_in, mac_a, mac_b, mac_acc_in,
    input  mac_acc_out, mac_valid_out
  );

  modport slave (
    input  mac_en, mac_valid_in, mac_a, mac_b, mac_acc_in,
    output mac_acc_out, mac_valid_out
  );
endinterface

// File: rtl/fxp_round_sat.sv
// Combinational requantiser: round half up, arithmetic shift by FRAC_BITS, saturate
// to a signed DATA_WIDTH result.
//   acc : signed accumulator input
//   res : rounded, saturated result
module fxp_round_sat
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 15
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] res
);
  // One guard bit so adding the rounding constant cannot overflow.
  localparam int unsigned SumWidth = ACC_WIDTH + 1;
  localparam logic signed [SumWidth-1:0] RndC = SumWidth'(rnd_const(FRAC_BITS));
  localparam logic signed [SumWidth-1:0] MaxC = SumWidth'(sat_max(DATA_WIDTH));
  localparam logic signed [SumWidth-1:0] MinC = SumWidth'(sat_min(DATA_WIDTH));

  logic signed [SumWidth-1:0] sum;
  logic signed [SumWidth-1:0] shifted;

  always_comb begin
    sum     = $signed({acc[ACC_WIDTH-1], acc}) + RndC;
    shifted = sum >>> FRAC_BITS;
    if (shifted > MaxC) begin
      res = MaxC[DATA_WIDTH-1:0];
    end else if (shifted < MinC) begin
      res = MinC[DATA_WIDTH-1:0];
    end else begin
      res = shifted[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer driving one mac_unit: fetches operand pairs from the input and
// weight buffers, issues one MAC op per tap, feeds the running sum back via mac_acc_in
// and returns a rounded, saturated Q1.15 result.
//   clk, rst_n                : clock, asynchronous active-low reset
//   start, len, base_x/base_w : job request (sampled in IDLE only), bias : Q1.15 bias
//   busy                      : FSM not in IDLE
//   rd_en, x_addr, w_addr     : buffer read port; x_data/w_data valid one cycle later
//   mac                       : issue/result channel to the mac_unit
//   res_valid/res_ready       : result handshake; res_data rounded result, res_acc raw sum
//   err                       : timeout on this job, sticky until the next accepted start
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FRAC_BITS  = 15,
  parameter bit          PIPELINED  = 1'b1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          len,
  input  logic [ADDR_WIDTH-1:0]        base_x,
  input  logic [ADDR_WIDTH-1:0]        base_w,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic                         busy,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        x_addr,
  output logic [ADDR_WIDTH-1:0]        w_addr,
  input  logic signed [DATA_WIDTH-1:0] x_data,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  mac_seq_ctrl_if.master               mac,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [DATA_WIDTH-1:0] res_data,
  output logic signed [ACC_WIDTH-1:0]  res_acc,
  output logic                         err
);
  localparam int unsigned CntWidth   = ADDR_WIDTH + 1;
  localparam int unsigned TimerWidth = $clog2(TIMEOUT + 1);

  state_e                       state_q;
  logic [CntWidth-1:0]          len_q, cnt_q, cnt_inc;
  logic [ADDR_WIDTH-1:0]        base_x_q, base_w_q;
  logic [ADDR_WIDTH-1:0]        x_addr_q, w_addr_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, res_acc_q, bias_acc;
  logic signed [DATA_WIDTH-1:0] a_q, b_q;
  logic [TimerWidth-1:0]        wait_q;
  logic                         busy_q, rd_en_q, mac_en_q, res_valid_q, err_q;

  assign cnt_inc  = cnt_q + CntWidth'(1);
  assign bias_acc = $signed({{(ACC_WIDTH - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias}) <<< FRAC_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      base_x_q    <= '0;
      base_w_q    <= '0;
      x_addr_q    <= '0;
      w_addr_q    <= '0;
      acc_q       <= '0;
      res_acc_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_en_q  <= 1'b0;
      mac_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q    <= len;
            base_x_q <= base_x;
            base_w_q <= base_w;
            acc_q    <= bias_acc;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            if (len == '0) begin
              state_q     <= StDone;
              res_acc_q   <= bias_acc;
              res_valid_q <= 1'b1;
            end else begin
              state_q  <= StFetch;
              rd_en_q  <= 1'b1;
              x_addr_q <= base_x;
              w_addr_q <= base_w;
            end
          end
        end
        StFetch: begin
          if (PIPELINED) begin
            state_q <= StIssueA;
          end else begin
            state_q  <= StIssue;
            mac_en_q <= 1'b1;
          end
        end
        StIssueA: begin
          a_q      <= x_data;
          b_q      <= w_data;
          mac_en_q <= 1'b1;
          state_q  <= StIssue;
        end
        StIssue: begin
          wait_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A result on the timeout edge still counts as a result.
          if (mac.mac_valid_out) begin
            acc_q <= mac.mac_acc_out;
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q     <= StDone;
              res_acc_q   <= mac.mac_acc_out;
              res_valid_q <= 1'b1;
            end else begin
              state_q  <= StFetch;
              rd_en_q  <= 1'b1;
              x_addr_q <= base_x_q + cnt_inc[ADDR_WIDTH-1:0];
              w_addr_q <= base_w_q + cnt_inc[ADDR_WIDTH-1:0];
            end
          end else if (wait_q == TimerWidth'(TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            state_q     <= StDone;
            res_acc_q   <= acc_q;
            res_valid_q <= 1'b1;
          end else begin
            wait_q <= wait_q + TimerWidth'(1);
          end
        end
        StDone: begin
          if (res_ready) begin
            state_q     <= StIdle;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Unpipelined MAC takes operands straight from the buffer in the ISSUE cycle.
  if (PIPELINED) begin : g_pipe
    assign mac.mac_a = a_q;
    assign mac.mac_b = b_q;
  end else begin : g_nopipe
    assign mac.mac_a = (state_q == StIssue) ? x_data : '0;
    assign mac.mac_b = (state_q == StIssue) ? w_data : '0;
  end

  assign mac.mac_en       = mac_en_q;
  assign mac.mac_valid_in = mac_en_q;
  assign mac.mac_acc_in   = acc_q;

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign x_addr    = x_addr_q;
  assign w_addr    = w_addr_q;
  assign res_valid = res_valid_q;
  assign res_acc   = res_acc_q;
  assign err       = err_q;

  fxp_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .acc(res_acc_q),
    .res(res_data)
  );
endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [8:0]         len;
  logic [7:0]         base_x, base_w;
  logic signed [15:0] bias;
  logic               busy, rd_en;
  logic [7:0]         x_addr, w_addr;
  logic signed [15:0] x_data, w_data;
  logic               res_valid, res_ready, err;
  logic signed [15:0] res_data;
  logic signed [39:0] res_acc;

  int checks = 0;
  int failures = 0;

  logic signed [15:0] xbuf [256];
  logic signed [15:0] wbuf [256];
  logic [7:0]         addr_log [1024];
  int                 addr_n = 0;
  int                 mac_en_cnt = 0;
  int                 stub_lat = 1;
  logic               stub_mute = 1'b0;
  int                 stub_cnt = 0;

  mac_seq_ctrl_if #(.DATA_WIDTH(16), .ACC_WIDTH(40)) mac_bus ();

  mac_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .base_x   (base_x),
    .base_w   (base_w),
    .bias     (bias),
    .busy     (busy),
    .rd_en    (rd_en),
    .x_addr   (x_addr),
    .w_addr   (w_addr),
    .x_data   (x_data),
    .w_data   (w_data),
    .mac      (mac_bus.master),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_acc  (res_acc),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Buffers: registered read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      x_data             <= xbuf[x_addr];
      w_data             <= wbuf[w_addr];
      addr_log[addr_n % 1024] <= x_addr;
      addr_n             <= addr_n + 1;
    end
  end

  // MAC stub: result = acc_in + a*b, valid stub_lat cycles after mac_en.
  always @(posedge clk) begin
    mac_bus.mac_valid_out <= 1'b0;
    if (mac_bus.mac_en) begin
      mac_en_cnt          <= mac_en_cnt + 1;
      mac_bus.mac_acc_out <= mac_bus.mac_acc_in + mac_bus.mac_a * mac_bus.mac_b;
      if (stub_lat == 1) mac_bus.mac_valid_out <= !stub_mute;
      else stub_cnt <= stub_lat - 1;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) mac_bus.mac_valid_out <= !stub_mute;
    end
  end

  task automatic start_job(input logic [8:0] l, input logic [7:0] bx, input logic [7:0] bw,
                           input logic signed [15:0] b);
    @(negedge clk);
    len = l; base_x = bx; base_w = bw; bias = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle number (start sample = cycle 0) in which res_valid is first seen.
  task automatic wait_result(output int cyc);
    cyc = 1;
    while (!res_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept();
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, rd_en, mac_bus.mac_en, mac_bus.mac_valid_in, res_valid, err} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b required 000000",
                           {busy, rd_en, mac_bus.mac_en, mac_bus.mac_valid_in, res_valid, err});
    end
    checks++;
    if (res_acc !== 40'sd0 || res_data !== 16'sd0 || x_addr !== 8'd0 || w_addr !== 8'd0 ||
        mac_bus.mac_a !== 16'sd0 || mac_bus.mac_b !== 16'sd0 || mac_bus.mac_acc_in !== 40'sd0) begin
      failures++; $display("FAIL reset_data: res_acc=%0d res_data=%0d x_addr=%0d required 0",
                           res_acc, res_data, x_addr);
    end
  endtask

  task automatic test_single_tap();
    int cyc, en0;
    xbuf[0] = 16'sd16384; wbuf[0] = 16'sd8192;
    en0 = mac_en_cnt;
    start_job(9'd1, 8'd0, 8'd0, 16'sd0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b required 1", busy); end
    wait_result(cyc);
    checks++;
    if (cyc !== 5) begin failures++; $display("FAIL single_cycle: got %0d required 5", cyc); end
    checks++;
    if (res_acc !== 40'sd134217728) begin
      failures++; $display("FAIL single_acc: got %0d required 134217728", res_acc);
    end
    checks++;
    if (res_data !== 16'sd4096) begin
      failures++; $display("FAIL single_data: got %0d required 4096", res_data);
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL single_err: got %b required 0", err); end
    checks++;
    if (mac_en_cnt - en0 !== 1) begin
      failures++; $display("FAIL single_mac_en: got %0d required 1", mac_en_cnt - en0);
    end
    accept();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got %b required 0", busy); end
  endtask

  task automatic test_neg_round();
    int cyc;
    xbuf[10] = 16'sd3277; wbuf[10] = -16'sd3277;
    start_job(9'd1, 8'd10, 8'd10, 16'sd0);
    wait_result(cyc);
    checks++;
    if (res_acc !== -40'sd10738729) begin
      failures++; $display("FAIL neg_acc: got %0d required -10738729", res_acc);
    end
    checks++;
    if (res_data !== -16'sd328) begin
      failures++; $display("FAIL neg_data: got %0d required -328", res_data);
    end
    accept();
  endtask

  task automatic test_saturation();
    int cyc;
    for (int i = 0; i < 4; i++) begin
      xbuf[20 + i] = 16'sd32767;  wbuf[20 + i] = 16'sd32767;
      xbuf[30 + i] = -16'sd32768; wbuf[30 + i] = 16'sd32767;
    end
    start_job(9'd4, 8'd20, 8'd20, 16'sd0);
    wait_result(cyc);
    checks++;
    if (cyc !== 17) begin failures++; $display("FAIL sat_cycle: got %0d required 17", cyc); end
    checks++;
    if (res_acc !== 40'sd4294705156) begin
      failures++; $display("FAIL sat_pos_acc: got %0d required 4294705156", res_acc);
    end
    checks++;
    if (res_data !== 16'sd32767) begin
      failures++; $display("FAIL sat_pos_data: got %0d required 32767", res_data);
    end
    accept();
    start_job(9'd4, 8'd30, 8'd30, 16'sd0);
    wait_result(cyc);
    checks++;
    if (res_acc !== -40'sd4294836224) begin
      failures++; $display("FAIL sat_neg_acc: got %0d required -4294836224", res_acc);
    end
    checks++;
    if (res_data !== -16'sd32768) begin
      failures++; $display("FAIL sat_neg_data: got %0d required -32768", res_data);
    end
    accept();
  endtask

  task automatic test_bias_only();
    int cyc, en0;
    en0 = mac_en_cnt;
    start_job(9'd0, 8'd0, 8'd0, 16'sd100);
    wait_result(cyc);
    checks++;
    if (cyc !== 1) begin failures++; $display("FAIL bias_cycle: got %0d required 1", cyc); end
    checks++;
    if (res_acc !== 40'sd3276800) begin
      failures++; $display("FAIL bias_acc: got %0d required 3276800", res_acc);
    end
    checks++;
    if (res_data !== 16'sd100) begin
      failures++; $display("FAIL bias_data: got %0d required 100", res_data);
    end
    checks++;
    if (mac_en_cnt - en0 !== 0) begin
      failures++; $display("FAIL bias_mac_en: got %0d required 0", mac_en_cnt - en0);
    end
    accept();
  endtask

  task automatic test_backpressure();
    int cyc, en0;
    xbuf[0] = 16'sd16384; wbuf[0] = 16'sd8192;
    start_job(9'd1, 8'd0, 8'd0, 16'sd0);
    wait_result(cyc);
    en0 = mac_en_cnt;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 9'd3; base_x = 8'd20; base_w = 8'd20;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_acc !== 40'sd134217728 || res_data !== 16'sd4096) begin
        failures++; $display("FAIL bp_hold[%0d]: valid=%b acc=%0d data=%0d required 1/134217728/4096",
                             i, res_valid, res_acc, res_data);
      end
    end
    start = 1'b0;
    accept();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_queue: busy=%b required 0", busy); end
    checks++;
    if (mac_en_cnt - en0 !== 0) begin
      failures++; $display("FAIL bp_mac_en: got %0d required 0", mac_en_cnt - en0);
    end
  endtask

  task automatic test_addr_wrap();
    int cyc, n0;
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'd254; exp_addr[1] = 8'd255; exp_addr[2] = 8'd0; exp_addr[3] = 8'd1;
    for (int i = 0; i < 4; i++) begin
      xbuf[exp_addr[i]] = 16'sd2; wbuf[100 + i] = 16'sd16384;
    end
    n0 = addr_n;
    start_job(9'd4, 8'd254, 8'd100, 16'sd0);
    wait_result(cyc);
    checks++;
    if (addr_n - n0 !== 4) begin
      failures++; $display("FAIL wrap_reads: got %0d required 4", addr_n - n0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_log[(n0 + i) % 1024] !== exp_addr[i]) begin
        failures++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", i,
                             addr_log[(n0 + i) % 1024], exp_addr[i]);
      end
    end
    checks++;
    if (res_acc !== 40'sd131072 || res_data !== 16'sd4) begin
      failures++; $display("FAIL wrap_result: acc=%0d data=%0d required 131072/4", res_acc, res_data);
    end
    accept();
  endtask

  task automatic test_timeout();
    int cyc, en0;
    stub_mute = 1'b1;
    en0 = mac_en_cnt;
    start_job(9'd2, 8'd0, 8'd0, 16'sd5);
    wait_result(cyc);
    checks++;
    if (cyc !== 20) begin failures++; $display("FAIL tmo_cycle: got %0d required 20", cyc); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b required 1", err); end
    checks++;
    if (res_acc !== 40'sd163840 || res_data !== 16'sd5) begin
      failures++; $display("FAIL tmo_result: acc=%0d data=%0d required 163840/5", res_acc, res_data);
    end
    checks++;
    if (mac_en_cnt - en0 !== 1) begin
      failures++; $display("FAIL tmo_mac_en: got %0d required 1", mac_en_cnt - en0);
    end
    accept();
    stub_mute = 1'b0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %b required 1", err); end
    start_job(9'd0, 8'd0, 8'd0, 16'sd7);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL tmo_clear: got %b required 0", err); end
    wait_result(cyc);
    accept();
  endtask

  task automatic test_mid_reset();
    int cyc, guard;
    stub_lat = 3;
    xbuf[0] = 16'sd16384; wbuf[0] = 16'sd8192;
    start_job(9'd2, 8'd0, 8'd0, 16'sd0);
    guard = 0;
    while (!mac_bus.mac_en && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (mac_bus.mac_en !== 1'b1) begin
      failures++; $display("FAIL rst_issue_seen: got %b required 1", mac_bus.mac_en);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Stale MAC result pops out while idle and must be ignored.
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      failures++; $display("FAIL rst_stray_valid: busy=%b res_valid=%b required 0/0", busy, res_valid);
    end
    start_job(9'd1, 8'd0, 8'd0, 16'sd0);
    wait_result(cyc);
    checks++;
    if (cyc !== 7) begin failures++; $display("FAIL rst_job_cycle: got %0d required 7", cyc); end
    checks++;
    if (res_acc !== 40'sd134217728 || res_data !== 16'sd4096 || err !== 1'b0) begin
      failures++; $display("FAIL rst_job_result: acc=%0d data=%0d err=%b required 134217728/4096/0",
                           res_acc, res_data, err);
    end
    accept();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    len = '0; base_x = '0; base_w = '0; bias = '0;
    for (int i = 0; i < 256; i++) begin xbuf[i] = '0; wbuf[i] = '0; end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_tap();
    test_neg_round();
    test_saturation();
    test_bias_only();
    test_backpressure();
    test_addr_wrap();
    test_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
